// File: rtl/tetris_input_scheduler.sv
// tetris_input_scheduler
// Turns debounced key levels into game-tick-aligned, one-hot command pulses
// for tetris_game: delayed auto-shift on left/right, a soft-drop repeat rate,
// latched edge-triggered rotate/drop, and one command per tick at most.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   tick_game             one-cycle game tick strobe
//   key_left/right/down/rotate/drop   debounced key levels
//   game_busy             core locking / hard-dropping / clearing lines
//   game_over             core game-over flag
//   tick_out              tick_game delayed one clk
//   cmd_left/right/down/rotate/drop   command pulses, only in tick_out cycles
//   cmd_lost              a left/right/down request was discarded this tick
//
// Build option: define TETRIS_INPUT_SYNC_EN to pass every key through a
// 2-flop synchronizer before use (key-to-latch latency 3 clk instead of 1).
module tetris_input_scheduler #(
    parameter int unsigned DAS_DELAY = 10,
    parameter int unsigned DAS_RATE  = 3,
    parameter int unsigned SOFT_RATE = 1,
    parameter int unsigned CNT_W     = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_game,
    input  logic key_left,
    input  logic key_right,
    input  logic key_down,
    input  logic key_rotate,
    input  logic key_drop,
    input  logic game_busy,
    input  logic game_over,
    output logic tick_out,
    output logic cmd_left,
    output logic cmd_right,
    output logic cmd_down,
    output logic cmd_rotate,
    output logic cmd_drop,
    output logic cmd_lost
);

    localparam int unsigned NKEY = 5;

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_DELAY  = 2'd1,
        H_REPEAT = 2'd2
    } h_state_t;

    // Key bundle order: {drop, rotate, down, right, left}
    logic [NKEY-1:0] keys_raw;
    logic [NKEY-1:0] keys_s;
    assign keys_raw = {key_drop, key_rotate, key_down, key_right, key_left};

`ifdef TETRIS_INPUT_SYNC_EN
    logic [NKEY-1:0] sync1;
    logic [NKEY-1:0] sync2;

    // Two-flop synchronizer ahead of edge capture and level decoding
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
        end
    end
    assign keys_s = sync2;
`else
    assign keys_s = keys_raw;
`endif

    // State
    logic [1:0]       edge_prev;   // previous {drop, rotate} level
    logic             drop_pend;
    logic             rot_pend;
    h_state_t         h_state;
    logic             h_dir;       // 1 = right, 0 = left
    logic [CNT_W-1:0] h_cnt;
    logic             s_act;       // soft drop first press already issued
    logic [CNT_W-1:0] s_cnt;

    // Next-state / decision signals
    logic             drop_rise_c;
    logic             rot_rise_c;
    logic             dir_any_c;
    logic             dir_right_c;
    logic             h_req_c;
    logic             h_fresh_c;
    logic [CNT_W-1:0] h_dec_c;
    h_state_t         h_state_n_c;
    logic [CNT_W-1:0] h_cnt_n_c;
    logic             h_dir_n_c;
    logic             d_req_c;
    logic             d_fresh_c;
    logic [CNT_W-1:0] s_dec_c;
    logic             s_act_n_c;
    logic [CNT_W-1:0] s_cnt_n_c;
    logic             ok_c;
    logic             win_drop_c;
    logic             win_rot_c;
    logic             win_h_c;
    logic             win_d_c;
    logic             lost_c;

    assign drop_rise_c = keys_s[4] & ~edge_prev[1];
    assign rot_rise_c  = keys_s[3] & ~edge_prev[0];
    assign dir_any_c   = keys_s[0] ^ keys_s[1];
    assign dir_right_c = keys_s[1] & ~keys_s[0];
    assign h_dec_c     = (h_cnt == '0) ? '0 : h_cnt - CNT_W'(1);
    assign s_dec_c     = (s_cnt == '0) ? '0 : s_cnt - CNT_W'(1);

    // Per-tick requests, arbitration and counter next-state
    always_comb begin
        h_req_c     = 1'b0;
        h_fresh_c   = 1'b0;
        h_state_n_c = h_state;
        h_cnt_n_c   = h_cnt;
        h_dir_n_c   = h_dir;
        d_req_c     = 1'b0;
        d_fresh_c   = 1'b0;
        s_act_n_c   = s_act;
        s_cnt_n_c   = s_cnt;

        case (h_state)
            H_IDLE: begin
                if (dir_any_c) begin
                    h_req_c   = 1'b1;
                    h_fresh_c = 1'b1;
                end
            end
            H_DELAY, H_REPEAT: begin
                if (!dir_any_c) begin
                    h_state_n_c = H_IDLE;
                    h_cnt_n_c   = '0;
                end else if (dir_right_c != h_dir) begin
                    h_req_c   = 1'b1;
                    h_fresh_c = 1'b1;
                end else if (h_dec_c == '0) begin
                    h_req_c     = 1'b1;
                    h_cnt_n_c   = CNT_W'(DAS_RATE);
                    h_state_n_c = H_REPEAT;
                end else begin
                    h_cnt_n_c = h_dec_c;
                end
            end
            default: begin
                h_state_n_c = H_IDLE;
                h_cnt_n_c   = '0;
            end
        endcase

        if (!keys_s[2]) begin
            s_act_n_c = 1'b0;
            s_cnt_n_c = '0;
        end else if (!s_act) begin
            d_req_c   = 1'b1;
            d_fresh_c = 1'b1;
        end else if (s_dec_c == '0) begin
            d_req_c   = 1'b1;
            s_cnt_n_c = CNT_W'(SOFT_RATE);
        end else begin
            s_cnt_n_c = s_dec_c;
        end

        ok_c       = ~game_busy & ~game_over;
        win_drop_c = ok_c & drop_pend;
        win_rot_c  = ok_c & ~drop_pend & rot_pend;
        win_h_c    = ok_c & ~drop_pend & ~rot_pend & h_req_c;
        win_d_c    = ok_c & ~drop_pend & ~rot_pend & ~h_req_c & d_req_c;
        lost_c     = ~game_over & ((h_req_c & ~win_h_c) | (d_req_c & ~win_d_c));

        // A first press is only consumed once it actually issues, so a
        // press that loses arbitration is retried on the next tick.
        if (h_fresh_c) begin
            if (win_h_c) begin
                h_state_n_c = H_DELAY;
                h_cnt_n_c   = CNT_W'(DAS_DELAY);
                h_dir_n_c   = dir_right_c;
            end else begin
                h_state_n_c = H_IDLE;
                h_cnt_n_c   = '0;
            end
        end
        if (d_fresh_c && win_d_c) begin
            s_act_n_c = 1'b1;
            s_cnt_n_c = CNT_W'(SOFT_RATE);
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_prev  <= '0;
            drop_pend  <= 1'b0;
            rot_pend   <= 1'b0;
            h_state    <= H_IDLE;
            h_dir      <= 1'b0;
            h_cnt      <= '0;
            s_act      <= 1'b0;
            s_cnt      <= '0;
            tick_out   <= 1'b0;
            cmd_left   <= 1'b0;
            cmd_right  <= 1'b0;
            cmd_down   <= 1'b0;
            cmd_rotate <= 1'b0;
            cmd_drop   <= 1'b0;
            cmd_lost   <= 1'b0;
        end else begin
            edge_prev <= keys_s[4:3];
            tick_out  <= tick_game;

            cmd_drop   <= tick_game & win_drop_c;
            cmd_rotate <= tick_game & win_rot_c;
            cmd_left   <= tick_game & win_h_c & ~dir_right_c;
            cmd_right  <= tick_game & win_h_c & dir_right_c;
            cmd_down   <= tick_game & win_d_c;
            cmd_lost   <= tick_game & lost_c;

            // Pending latches: a new edge while pending does not stack
            if (game_over) begin
                drop_pend <= 1'b0;
                rot_pend  <= 1'b0;
            end else begin
                if (tick_game && win_drop_c) begin
                    drop_pend <= 1'b0;
                end else if (drop_rise_c) begin
                    drop_pend <= 1'b1;
                end
                if (tick_game && win_rot_c) begin
                    rot_pend <= 1'b0;
                end else if (rot_rise_c) begin
                    rot_pend <= 1'b1;
                end
            end

            // Counters/FSM advance on non-busy ticks, freeze while busy
            if (game_over) begin
                h_state <= H_IDLE;
                h_dir   <= 1'b0;
                h_cnt   <= '0;
                s_act   <= 1'b0;
                s_cnt   <= '0;
            end else if (tick_game && !game_busy) begin
                h_state <= h_state_n_c;
                h_dir   <= h_dir_n_c;
                h_cnt   <= h_cnt_n_c;
                s_act   <= s_act_n_c;
                s_cnt   <= s_cnt_n_c;
            end
        end
    end

endmodule

// File: tb/tb_tetris_input_scheduler.sv
// Bench for tetris_input_scheduler: each tick pushes its expected command
// vector {lost, drop, rotate, down, right, left}; a monitor pops it when
// tick_out pulses and checks that no command appears outside tick_out.
module tb_tetris_input_scheduler;

    logic clk = 1'b0;
    logic rst, tick_game;
    logic key_left, key_right, key_down, key_rotate, key_drop;
    logic game_busy, game_over;
    logic tick_out, cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop, cmd_lost;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;
    logic [5:0] sb[$];

    localparam logic [5:0] E_NONE = 6'b000000;
    localparam logic [5:0] E_L    = 6'b000001;
    localparam logic [5:0] E_R    = 6'b000010;
    localparam logic [5:0] E_D    = 6'b000100;
    localparam logic [5:0] E_ROT  = 6'b001000;
    localparam logic [5:0] E_DROP = 6'b010000;
    localparam logic [5:0] E_LOST = 6'b100000;

    always #5 clk = ~clk;

    tetris_input_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .tick_game  (tick_game),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_down   (key_down),
        .key_rotate (key_rotate),
        .key_drop   (key_drop),
        .game_busy  (game_busy),
        .game_over  (game_over),
        .tick_out   (tick_out),
        .cmd_left   (cmd_left),
        .cmd_right  (cmd_right),
        .cmd_down   (cmd_down),
        .cmd_rotate (cmd_rotate),
        .cmd_drop   (cmd_drop),
        .cmd_lost   (cmd_lost)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse tick_game for one clk; the expected result is queued first
    task automatic do_tick(input logic [5:0] exp);
        sb.push_back(exp);
        @(negedge clk);
        tick_game = 1'b1;
        @(negedge clk);
        tick_game = 1'b0;
        wait_clk(2);
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (mon_en) begin
            logic [5:0] got;
            got = {cmd_lost, cmd_drop, cmd_rotate, cmd_down, cmd_right, cmd_left};
            if (tick_out) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", {2'b00, got}, 8'hFF);
                end else begin
                    logic [5:0] exp;
                    exp = sb.pop_front();
                    check_eq("tick_cmds", {2'b00, got}, {2'b00, exp});
                end
            end else begin
                check_eq("idle_cmds", {2'b00, got}, 8'h00);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick_game = 1'b0;
        key_left = 0; key_right = 0; key_down = 0; key_rotate = 0; key_drop = 0;
        game_busy = 0; game_over = 0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        check_eq("reset_outs",
                 {1'b0, tick_out, cmd_lost, cmd_drop, cmd_rotate, cmd_down, cmd_right, cmd_left},
                 8'h00);
        // Reset wins over a coincident tick
        rst = 1'b1; tick_game = 1'b1;
        wait_clk(1);
        check_eq("rst_wins_tick", {7'd0, tick_out}, 8'h00);
        rst = 1'b0; tick_game = 1'b0;
        wait_clk(2);
        mon_en = 1'b1;

        // No keys: bare tick_out pulses
        for (int i = 0; i < 3; i++) do_tick(E_NONE);

        // Hold right for 20 ticks: moves on 1, 11, 14, 17, 20
        key_right = 1'b1;
        wait_clk(4);
        for (int t = 1; t <= 20; t++) begin
            do_tick((t == 1 || t == 11 || t == 14 || t == 17 || t == 20) ? E_R : E_NONE);
        end
        key_right = 1'b0;
        wait_clk(4);
        do_tick(E_NONE);

        // Single short rotate pulse between ticks
        key_rotate = 1'b1; wait_clk(1); key_rotate = 1'b0;
        wait_clk(4);
        do_tick(E_ROT);
        do_tick(E_NONE);

        // Two rotate pulses between ticks issue once
        key_rotate = 1'b1; wait_clk(1); key_rotate = 1'b0; wait_clk(1);
        key_rotate = 1'b1; wait_clk(1); key_rotate = 1'b0;
        wait_clk(4);
        do_tick(E_ROT);
        do_tick(E_NONE);

        // Drop beats left; left's first press retried next tick
        key_drop = 1'b1; key_left = 1'b1;
        wait_clk(4);
        do_tick(E_DROP | E_LOST);
        do_tick(E_L);
        do_tick(E_NONE);
        key_drop = 1'b0; key_left = 1'b0;
        wait_clk(4);
        do_tick(E_NONE);

        // Busy suppresses soft drop, down issues once busy drops
        game_busy = 1'b1; key_down = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 3; i++) do_tick(E_LOST);
        game_busy = 1'b0;
        do_tick(E_D);
        do_tick(E_D);
        key_down = 1'b0;
        wait_clk(4);
        do_tick(E_NONE);

        // Both horizontal keys count as none
        key_left = 1'b1; key_right = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 5; i++) do_tick(E_NONE);
        key_right = 1'b0;
        wait_clk(4);
        do_tick(E_L);
        do_tick(E_NONE);
        key_left = 1'b0;
        wait_clk(4);
        do_tick(E_NONE);

        // Rotate > horizontal > down, with losers flagged
        key_right = 1'b1; key_down = 1'b1;
        key_rotate = 1'b1; wait_clk(1); key_rotate = 1'b0;
        wait_clk(4);
        do_tick(E_ROT | E_LOST);
        do_tick(E_R | E_LOST);
        do_tick(E_D);
        do_tick(E_D);
        key_right = 1'b0; key_down = 1'b0;
        wait_clk(4);
        do_tick(E_NONE);

        // game_over clears a pending rotate; held key gives no new edge
        key_rotate = 1'b1;
        wait_clk(4);
        game_over = 1'b1; key_left = 1'b1;
        wait_clk(2);
        do_tick(E_NONE);
        game_over = 1'b0; key_left = 1'b0;
        wait_clk(4);
        do_tick(E_NONE);
        key_rotate = 1'b0;
        wait_clk(4);
        do_tick(E_NONE);

        wait_clk(3);
        check_eq("sb_drain", 8'(sb.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
